sweep_result_buf: RTL

Capture buffer downstream of the frequency-sweep control path inside the ASG channel. Stores one record per sweep point: magnitude ratio, phase, channel-A magnitude and channel-B magnitude, indexed by the point address the control path emits with its write strobe. Tracks sweep progress and flags completion. Exposes the stored records to the system bus through a pipelined read port.

---
 rtl/sweep_buf_pkg.sv | 18 +
 rtl/sweep_buf_ram.sv | 38 +++
 rtl/sweep_result_buf.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sweep_buf_pkg.sv
// sweep_buf_pkg: shared types and constants for the sweep result buffer.
//   state_e  : capture state machine encoding (IDLE, ARMED, CAPTURE, DONE)
//   WSEL_*   : word-select values carried in rd_addr_i[1:0]
package sweep_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] WSEL_MOD   = 2'd0;
  localparam logic [1:0] WSEL_PHASE = 2'd1;
  localparam logic [1:0] WSEL_MODA  = 2'd2;
  localparam logic [1:0] WSEL_MODB  = 2'd3;

endpackage

// File: rtl/sweep_buf_ram.sv
// sweep_buf_ram: simple dual-port RAM, read-first, registered read data.
//   clk_i    : clock
//   we_i     : write enable, waddr_i / wdata_i written at the clock edge
//   re_i     : read enable, rdata_o loads mem[raddr_i] at the clock edge
//   rdata_o  : registered read data (old contents on a same-address write)
// Contents are not reset.
module sweep_buf_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Both updates are non-blocking, so a read of the address being written
  // returns the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sweep_result_buf.sv
// sweep_result_buf: capture buffer for frequency-sweep results.
// Stores {mod, phase, modA, modB} per sweep point, tracks progress and
// completion, and serves the records through a two-stage read pipeline.
//   dac_clk_i / dac_rst_i          : clock, synchronous active-high reset
//   arm_i, npts_i                  : start capture, index of last point
//   pnt_we_i, pnt_addr_i, pnt_*_i  : result strobe, point index, words
//   rd_en_i, rd_addr_i             : read request, {point index, word sel}
//   rd_data_o, rd_ack_o            : read data, valid two cycles after req
//   busy_o, done_o, irq_o          : ARMED|CAPTURE, DONE, DONE entry pulse
//   cnt_o, ovr_o                   : accepted writes, out-of-order sticky
// Optional feature (macro SWEEP_BUF_PEAK_EN): peak_mod_o / peak_idx_o
// report the largest mod word seen since arm and its first index.
module sweep_result_buf
  import sweep_buf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic                  arm_i,
  input  logic [ADDR_WIDTH-1:0] npts_i,
  input  logic                  pnt_we_i,
  input  logic [ADDR_WIDTH-1:0] pnt_addr_i,
  input  logic [DATA_WIDTH-1:0] pnt_mod_i,
  input  logic [DATA_WIDTH-1:0] pnt_phase_i,
  input  logic [DATA_WIDTH-1:0] pnt_moda_i,
  input  logic [DATA_WIDTH-1:0] pnt_modb_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH+1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_ack_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  irq_o,
  output logic [ADDR_WIDTH:0]   cnt_o,
  output logic                  ovr_o
`ifdef SWEEP_BUF_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0] peak_mod_o,
  output logic [ADDR_WIDTH-1:0] peak_idx_o
`endif
);

  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic                  irq_q, irq_d;
  logic                  rd_en_q, rd_en_d;
  logic [1:0]            wsel_q, wsel_d;
  logic                  rd_ack_q, rd_ack_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  accept;
  logic                  last_pt;
  logic [ADDR_WIDTH-1:0] rd_pnt;
  logic [DATA_WIDTH-1:0] rdata_mod, rdata_phase, rdata_moda, rdata_modb;

  // arm_i has priority: a strobe in the arming cycle is dropped entirely.
  assign accept  = pnt_we_i && !arm_i && (state_q == ARMED || state_q == CAPTURE);
  assign last_pt = (pnt_addr_i == npts_i);
  assign rd_pnt  = rd_addr_i[ADDR_WIDTH+1:2];

  sweep_buf_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram_mod (
    .clk_i(dac_clk_i), .we_i(accept), .waddr_i(pnt_addr_i), .wdata_i(pnt_mod_i),
    .re_i(rd_en_i), .raddr_i(rd_pnt), .rdata_o(rdata_mod)
  );
  sweep_buf_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram_phase (
    .clk_i(dac_clk_i), .we_i(accept), .waddr_i(pnt_addr_i), .wdata_i(pnt_phase_i),
    .re_i(rd_en_i), .raddr_i(rd_pnt), .rdata_o(rdata_phase)
  );
  sweep_buf_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram_moda (
    .clk_i(dac_clk_i), .we_i(accept), .waddr_i(pnt_addr_i), .wdata_i(pnt_moda_i),
    .re_i(rd_en_i), .raddr_i(rd_pnt), .rdata_o(rdata_moda)
  );
  sweep_buf_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram_modb (
    .clk_i(dac_clk_i), .we_i(accept), .waddr_i(pnt_addr_i), .wdata_i(pnt_modb_i),
    .re_i(rd_en_i), .raddr_i(rd_pnt), .rdata_o(rdata_modb)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    irq_d     = 1'b0;
    rd_en_d   = rd_en_i;
    wsel_d    = rd_addr_i[1:0];
    rd_ack_d  = rd_en_q;
    rd_data_d = rd_data_q;

    if (arm_i) begin
      state_d = ARMED;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (accept) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if ({1'b0, pnt_addr_i} != cnt_q) begin
        ovr_d = 1'b1;
      end
      if (last_pt) begin
        state_d = DONE;
        irq_d   = 1'b1;
      end else begin
        state_d = CAPTURE;
      end
    end

    // Second read stage: select the word from the registered RAM outputs.
    if (rd_en_q) begin
      unique case (wsel_q)
        WSEL_MOD:   rd_data_d = rdata_mod;
        WSEL_PHASE: rd_data_d = rdata_phase;
        WSEL_MODA:  rd_data_d = rdata_moda;
        WSEL_MODB:  rd_data_d = rdata_modb;
      endcase
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ovr_q     <= 1'b0;
      irq_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wsel_q    <= '0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      irq_q     <= irq_d;
      rd_en_q   <= rd_en_d;
      wsel_q    <= wsel_d;
      rd_ack_q  <= rd_ack_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy_o    = (state_q == ARMED) || (state_q == CAPTURE);
  assign done_o    = (state_q == DONE);
  assign irq_o     = irq_q;
  assign cnt_o     = cnt_q;
  assign ovr_o     = ovr_q;
  assign rd_ack_o  = rd_ack_q;
  assign rd_data_o = rd_data_q;

`ifdef SWEEP_BUF_PEAK_EN
  logic [DATA_WIDTH-1:0] peak_mod_q, peak_mod_d;
  logic [ADDR_WIDTH-1:0] peak_idx_q, peak_idx_d;

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    peak_mod_d = peak_mod_q;
    peak_idx_d = peak_idx_q;
    if (arm_i) begin
      peak_mod_d = '0;
      peak_idx_d = '0;
    end else if (accept && (pnt_mod_i > peak_mod_q)) begin
      peak_mod_d = pnt_mod_i;
      peak_idx_d = pnt_addr_i;
    end
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      peak_mod_q <= '0;
      peak_idx_q <= '0;
    end else begin
      peak_mod_q <= peak_mod_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  assign peak_mod_o = peak_mod_q;
  assign peak_idx_o = peak_idx_q;
`endif

endmodule
